// File: rtl/vx_dcache_responder.sv
// Local-memory responder for the dcache request bus.
// - Word-addressed storage with per-lane byte writes.
// - Each batch that contains reads produces one tagged response.
// - The response goes through a fixed-latency pipe and then an in-order FIFO.
module vx_dcache_responder #(
  parameter int unsigned NUM_REQS  = 4,
  parameter int unsigned TAG_WIDTH = 8,
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQS-1:0]                 dcache_req_valid,
  input  logic [NUM_REQS-1:0]                 dcache_req_rw,
  input  logic [NUM_REQS-1:0][3:0]            dcache_req_byteen,
  input  logic [NUM_REQS-1:0][29:0]           dcache_req_addr,
  input  logic [NUM_REQS-1:0][31:0]           dcache_req_data,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]  dcache_req_tag,
  output logic [NUM_REQS-1:0]                 dcache_req_ready,
  output logic                                dcache_rsp_valid,
  output logic [NUM_REQS-1:0]                 dcache_rsp_tmask,
  output logic [NUM_REQS-1:0][31:0]           dcache_rsp_data,
  output logic [TAG_WIDTH-1:0]                dcache_rsp_tag,
  input  logic                                dcache_rsp_ready,
  output logic                                busy
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [NUM_REQS-1:0]        tmask;
    logic [NUM_REQS-1:0][31:0]  data;
    logic [TAG_WIDTH-1:0]       tag;
  } rsp_t;

  logic [31:0]               mem_q [MEM_WORDS];
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [LATENCY-1:0]        pv_q;
  rsp_t                      pd_q [LATENCY];
  rsp_t                      fifo_q [RSP_DEPTH];
  logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             fcnt_q;

  logic                      req_ready, fire, rd_any;
  logic                      head_in_fifo, rsp_pop, fifo_pop, fifo_push;
  logic [NUM_REQS-1:0]       rd_mask;
  logic [NUM_REQS-1:0][AW-1:0] lane_idx;
  rsp_t                      cap, head;
  logic                      unused_addr;

  // Upper address bits alias onto the same word.
  assign unused_addr = ^dcache_req_addr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_ready        = (cnt_q < CW'(RSP_DEPTH));
  assign dcache_req_ready = {NUM_REQS{req_ready}};
  assign fire             = (|dcache_req_valid) & req_ready & ~reset;
  assign rd_mask          = dcache_req_valid & ~dcache_req_rw;
  assign rd_any           = fire & (|rd_mask);
  assign busy             = (cnt_q != '0);

  // Capture read data (pre-write) and the lowest-index read lane's tag.
  always_comb begin
    cap      = '0;
    lane_idx = '0;
    cap.tmask = rd_mask;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      lane_idx[i] = dcache_req_addr[i][AW-1:0];
      if (rd_mask[i]) cap.data[i] = mem_q[lane_idx[i]];
    end
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (rd_mask[NUM_REQS-1-i]) cap.tag = dcache_req_tag[NUM_REQS-1-i];
    end
  end

  // Byte-enabled writes; higher lanes are visited later so their bytes win.
  always_ff @(posedge clk) begin
    if (fire) begin
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (dcache_req_valid[i] && dcache_req_rw[i] && dcache_req_byteen[i][b])
            mem_q[lane_idx[i]][b*8 +: 8] <= dcache_req_data[i][b*8 +: 8];
        end
      end
    end
  end

  // The pipe output is presented directly when the FIFO is empty, and only
  // enqueued if it was not consumed that cycle; this makes rsp_valid appear
  // exactly LATENCY cycles after fire while preserving order and stability.
  assign head_in_fifo     = (fcnt_q != '0);
  assign dcache_rsp_valid = head_in_fifo | pv_q[LATENCY-1];
  assign head             = head_in_fifo ? fifo_q[rd_ptr_q] : pd_q[LATENCY-1];
  assign rsp_pop          = dcache_rsp_valid & dcache_rsp_ready;
  assign fifo_pop         = rsp_pop & head_in_fifo;
  assign fifo_push        = pv_q[LATENCY-1] & ~(rsp_pop & ~head_in_fifo);

  assign dcache_rsp_tmask = dcache_rsp_valid ? head.tmask : '0;
  assign dcache_rsp_data  = dcache_rsp_valid ? head.data  : '0;
  assign dcache_rsp_tag   = dcache_rsp_valid ? head.tag   : '0;

  // Non-stalling latency pipe: valids reset, payload free-running.
  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= rd_any;
      for (int unsigned k = 1; k < LATENCY; k++) pv_q[k] <= pv_q[k-1];
    end
    pd_q[0] <= cap;
    for (int unsigned k = 1; k < LATENCY; k++) pd_q[k] <= pd_q[k-1];
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_q[wr_ptr_q] <= pd_q[LATENCY-1];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({fifo_push, fifo_pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  // Outstanding-response credit count next state.
  always_comb begin
    cnt_d = cnt_q;
    if (rd_any && !rsp_pop)      cnt_d = cnt_q + 1'b1;
    else if (!rd_any && rsp_pop) cnt_d = cnt_q - 1'b1;
  end

  // Outstanding-response credit count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule
